// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: operand forwarding, load-use stall and branch flush control
// between decode and the ALU operand inputs of the in-order pipeline.
module pipe_hazard_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned BR_FLUSH  = 2,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]     id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_AW-1:0]             id_dst_addr,
  input  logic                          id_wen,
  input  logic                          id_is_load,
  input  logic [NUM_SRC*DATA_W-1:0]     rf_data,
  input  logic [FWD_DEPTH*DATA_W-1:0]   stage_data,
  input  logic                          br_taken,
  output logic                          stall,
  output logic                          flush,
  output logic                          issue,
  output logic [NUM_SRC*3-1:0]          fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]     operand,
  output logic [15:0]                   stall_count,
  output logic [15:0]                   flush_count
);

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [REG_AW-1:0] dst;
    logic              is_load;
  } entry_t;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  // The br_taken cycle is itself the first flush cycle, so the FLUSH state
  // only has to cover the remaining BR_FLUSH-1 cycles.
  localparam bit        MULTI_FLUSH  = (BR_FLUSH > 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'((BR_FLUSH > 1) ? BR_FLUSH - 2 : 0);

  entry_t            sb [FWD_DEPTH];
  state_t            state, state_next;
  logic [3:0]        fcnt, fcnt_next;
  logic              load_hit;
  logic [REG_AW-1:0] src;
  logic              is_zero;
  logic              found;
  logic              found_ld;
  int unsigned       sel_k;

  // Scoreboard shift: always advances, stall only blocks entry into stage 0.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int unsigned k = 0; k < FWD_DEPTH; k++) sb[k] <= '0;
    end else begin
      sb[0] <= issue ? {1'b1, id_wen, id_dst_addr, id_is_load} : '0;
      for (int unsigned k = 1; k < FWD_DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  // Per-source youngest-producer search, operand mux and load-use detection.
  always_comb begin
    fwd_sel  = '0;
    operand  = '0;
    load_hit = 1'b0;
    src      = '0;
    is_zero  = 1'b0;
    found    = 1'b0;
    found_ld = 1'b0;
    sel_k    = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src      = id_src_addr[i*REG_AW +: REG_AW];
      is_zero  = (ZERO_REG != 0) && (src == '0);
      found    = 1'b0;
      found_ld = 1'b0;
      sel_k    = 0;
      for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
        if (!found && id_src_used[i] && !is_zero && sb[k].valid && sb[k].wen &&
            (sb[k].dst == src)) begin
          found    = 1'b1;
          sel_k    = k;
          found_ld = sb[k].is_load && (k < LOAD_LAT);
        end
      end
      if (found) begin
        fwd_sel[i*3 +: 3]          = 3'(sel_k + 1);
        operand[i*DATA_W +: DATA_W] = stage_data[sel_k*DATA_W +: DATA_W];
        if (found_ld) load_hit = 1'b1;
      end else begin
        operand[i*DATA_W +: DATA_W] = rf_data[i*DATA_W +: DATA_W];
      end
      if (is_zero) operand[i*DATA_W +: DATA_W] = '0;
    end
  end

  // Flush FSM state and down-counter register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= S_IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  // Flush FSM next state; a branch in any state (re)starts the flush window.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    if (br_taken) begin
      if (MULTI_FLUSH) begin
        state_next = S_FLUSH;
        fcnt_next  = FLUSH_RELOAD;
      end else begin
        state_next = S_IDLE;
        fcnt_next  = '0;
      end
    end else if (state == S_FLUSH) begin
      if (fcnt == '0) state_next = S_IDLE;
      else            fcnt_next  = fcnt - 4'd1;
    end
  end

  // Pipeline control: flush wins over stall, issue only when neither.
  always_comb begin
    flush = br_taken | (state == S_FLUSH);
    stall = id_valid & ~flush & load_hit;
    issue = id_valid & ~stall & ~flush;
  end

  // Saturating event counters.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + 16'd1;
      if (flush && (flush_count != '1)) flush_count <= flush_count + 16'd1;
    end
  end

endmodule
